imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Parametrised, pipelined immediate generator for the RV32I/RV64I decode stage. Decodes all base
//  immediate formats (I, S, B, U, J, shift-amount) from an instruction word, sign-extends to XLEN and
//  buffers results in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
//  Sits between instruction fetch and the register-read/ALU-operand mux.
// PARAMETERS
//  XLEN   32  result width; legal values are 32 or 64
//  DEPTH  2   output FIFO entries; power of 2, >= 2
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous reset, active-low
//  flush_i      in   1       synchronous clear of all buffered entries
//  in_valid_i   in   1       instruction word valid
//  in_ready_o   out  1       block can accept an instruction this cycle
//  instr_i      in   32      instruction word; opcode = instr_i[6:0]
//  out_valid_o  out  1       head entry valid
//  out_ready_i  in   1       consumer takes the head entry
//  imm_o        out  XLEN    immediate at the FIFO head
//  fmt_o        out  3       format at the head: NONE=0, I=1, S=2, B=3, U=4, J=5, SH=6, Z=7
//  pc_rel_o     out  1       head immediate is PC-relative (B, J, AUIPC)
//  count_o      out  clog2(DEPTH)+1  number of occupied entries
// BEHAVIOUR
//  - Reset (reset=0, asynchronous): pointers=0, count_o=0, out_valid_o=0, imm_o=0, fmt_o=0, pc_rel_o=0.
//    After reset release, in_ready_o=1.
//  - Decode is combinational on instr_i. Push occurs when in_valid_i&&in_ready_o.
//    Pop occurs when out_valid_o&&out_ready_i.
//  - Latency: an entry pushed in cycle N is visible at the head in cycle N+1. There is no bypass:
//    a push into an empty FIFO still gives out_valid_o=1 only in cycle N+1.
//  - in_ready_o = (count<DEPTH) || out_ready_i. When the FIFO is full, a simultaneous push and pop is
//    allowed; count is unchanged.
//  - out_valid_o = (count!=0). When out_valid_o=0, imm_o, fmt_o and pc_rel_o hold their last values.
//    Consumers must not interpret them.
//  - Read and write pointers wrap modulo DEPTH. count_o ranges 0..DEPTH.
//  - flush_i: on the next edge, pointers and count are set to 0. flush_i overrides a push or pop in the
//    same cycle, and the word offered in that cycle is dropped. in_ready_o is unaffected by flush_i.
//  - Decode table (sx = sign-extend to XLEN):
//      0x13 with funct3 001/101 -> SH: zero-extended shamt = instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64)
//      0x13 (other funct3), 0x03, 0x67 -> I: sx(instr[31:20])
//      0x23 -> S: sx({instr[31:25],instr[11:7]})
//      0x63 -> B: sx({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}); pc_rel=1
//      0x37, 0x17 -> U: sx({instr[31:12],12'b0}); pc_rel=1 only for 0x17
//      0x6F -> J: sx({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}); pc_rel=1
//      any other opcode -> NONE: imm=0, pc_rel=0
//  - pc_rel=0 for every format and opcode not listed above as pc_rel=1.
// CONFIGURATION
//  - IMM_CSR_ZIMM_EN defined: opcode 0x73 with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) -> fmt Z,
//    imm = zero-extended instr[19:15].
//  - IMM_CSR_ZIMM_EN undefined: opcode 0x73 decodes as NONE (imm=0). Code 7 is never produced.
// STRUCTURE
//  - Package imm_pkg holds:
//    * enum imm_fmt_e (3 bits);
//    * opcode localparams OP_IMM, LOAD, JALR, STORE, BRANCH, LUI, AUIPC, JAL, SYSTEM;
//    * packed struct imm_entry_t {imm, fmt, pc_rel}.
//  - Sub-module imm_fifo is a generic DEPTH x imm_entry_t FIFO with pointers, count and flush.
//  - The top level holds the combinational decoder and the handshake glue.
// TESTING
//  1 Reset: hold reset=0 mid-traffic with count=2 -> outputs zero immediately; count_o=0; in_ready_o=1 after release.
//  2 Decode: addi x1,x0,-1 (0xFFF00093) -> imm=0xFFFFFFFF, fmt=I.
//    beq with offset -4 (0xFE000EE3) -> imm=0xFFFFFFFC, fmt=B, pc_rel=1.
//    lui 0x12345 (0x123450B7) -> imm=0x12345000, fmt=U.
//  3 Backpressure: DEPTH=2, out_ready_i=0, push 3 words -> third stalls (in_ready_o=0), count_o=2;
//    then out_ready_i=1 -> words drain in order, 1 per cycle.
//  4 Full and simultaneous: count=2 with in_valid_i=1, out_ready_i=1 -> push and pop together,
//    count stays 2, FIFO order preserved.
//  5 Flush: count=1 with flush_i=1 and a push in the same cycle -> next cycle count_o=0, out_valid_o=0,
//    pushed word lost.
//  6 XLEN=64 with IMM_CSR_ZIMM_EN: slli shamt 33 -> imm=33, fmt=SH. csrrwi zimm=31 -> imm=31, fmt=Z.
//    Without the macro, csrrwi gives fmt=NONE, imm=0.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types for the pipelined immediate generator: format codes, opcodes and the FIFO entry.
package imm_pkg;

  localparam int unsigned IMM_W   = 64;
  localparam int unsigned INSTR_W = 32;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6,
    FMT_Z    = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] JALR   = 7'h67;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] AUIPC  = 7'h17;
  localparam logic [6:0] JAL    = 7'h6F;
  localparam logic [6:0] SYSTEM = 7'h73;

  // Immediate is held at the widest XLEN; narrower builds drop the upper half at the output.
  typedef struct packed {
    logic [IMM_W-1:0] imm;
    imm_fmt_e         fmt;
    logic             pc_rel;
  } imm_entry_t;

  function automatic logic [IMM_W-1:0] sext32(input logic [INSTR_W-1:0] v);
    return {{(IMM_W-INSTR_W){v[INSTR_W-1]}}, v};
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out handshake bundle of imm_gen_pipe.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
);
  import imm_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     instr_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] imm_o;
  imm_fmt_e        fmt_o;
  logic            pc_rel_o;
  logic [CW-1:0]   count_o;

  modport master (
    output in_valid_i, instr_i, out_ready_i,
    input  in_ready_o, out_valid_o, imm_o, fmt_o, pc_rel_o, count_o
  );

  modport slave (
    input  in_valid_i, instr_i, out_ready_i,
    output in_ready_o, out_valid_o, imm_o, fmt_o, pc_rel_o, count_o
  );
endinterface

// File: rtl/imm_fifo.sv
// DEPTH-entry FIFO of imm_entry_t with a registered head, occupancy count and synchronous flush.
module imm_fifo
  import imm_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  imm_entry_t             wdata,
  output imm_entry_t             head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  imm_entry_t          mem [DEPTH];
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d, count_rem;
  imm_entry_t          head_q, head_d;
  logic                valid_q, valid_d;

  // Head register is loaded with whatever entry will sit at the read pointer next cycle;
  // it keeps its old value when the FIFO goes empty.
  always_comb begin
    count_rem = count_q - CW'(pop);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    wr_ptr_d  = wr_ptr_q + PW'(push);
    count_d   = count_rem + CW'(push);
    head_d    = head_q;
    valid_d   = (count_d != '0);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
    end else if (count_d != '0) begin
      head_d = (count_rem == '0) ? wdata : mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q] <= wdata;
  end

  assign head  = head_q;
  assign valid = valid_q;
  assign count = count_q;

endmodule

// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate decoder feeding a DEPTH-entry output FIFO with valid/ready on both sides.
// Optional build macro IMM_CSR_ZIMM_EN adds the CSR zimm (fmt Z) decode.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  imm_gen_pipe_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   instr;
  logic [2:0]    f3;
  imm_entry_t    dec;
  imm_entry_t    head;
  logic          push, pop, valid;
  logic [CW-1:0] count;

  assign instr = bus.instr_i;
  assign f3    = instr[14:12];

  // Combinational format decode and sign extension to the widest XLEN.
  always_comb begin
    dec.imm    = '0;
    dec.fmt    = FMT_NONE;
    dec.pc_rel = 1'b0;
    case (instr[6:0])
      OP_IMM: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.fmt = FMT_SH;
          dec.imm = (XLEN == 64) ? IMM_W'(instr[25:20]) : IMM_W'(instr[24:20]);
        end else begin
          dec.fmt = FMT_I;
          dec.imm = sext32({{20{instr[31]}}, instr[31:20]});
        end
      end
      LOAD, JALR: begin
        dec.fmt = FMT_I;
        dec.imm = sext32({{20{instr[31]}}, instr[31:20]});
      end
      STORE: begin
        dec.fmt = FMT_S;
        dec.imm = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
      end
      BRANCH: begin
        dec.fmt    = FMT_B;
        dec.pc_rel = 1'b1;
        dec.imm    = sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
      end
      LUI, AUIPC: begin
        dec.fmt    = FMT_U;
        dec.pc_rel = (instr[6:0] == AUIPC);
        dec.imm    = sext32({instr[31:12], 12'b0});
      end
      JAL: begin
        dec.fmt    = FMT_J;
        dec.pc_rel = 1'b1;
        dec.imm    = sext32({{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
      end
`ifdef IMM_CSR_ZIMM_EN
      SYSTEM: begin
        if (f3[2]) begin
          dec.fmt = FMT_Z;
          dec.imm = IMM_W'(instr[19:15]);
        end
      end
`else
      SYSTEM: dec.fmt = FMT_NONE;
`endif
      default: dec.fmt = FMT_NONE;
    endcase
  end

  // A full FIFO still accepts when the consumer drains the head in the same cycle.
  assign bus.in_ready_o = (count < CW'(DEPTH)) || bus.out_ready_i;
  assign push           = bus.in_valid_i && bus.in_ready_o;
  assign pop            = valid && bus.out_ready_i;

  imm_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush_i),
    .push  (push),
    .pop   (pop),
    .wdata (dec),
    .head  (head),
    .valid (valid),
    .count (count)
  );

  assign bus.out_valid_o = valid;
  assign bus.imm_o       = head.imm[XLEN-1:0];
  assign bus.fmt_o       = head.fmt;
  assign bus.pc_rel_o    = head.pc_rel;
  assign bus.count_o     = count;

  if (XLEN < IMM_W) begin : g_trim
    logic unused_hi;
    assign unused_hi = ^head.imm[IMM_W-1:XLEN];
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit DEPTH=2 instance plus a 64-bit instance for shamt/zimm decode.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .DEPTH(2)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64), .DEPTH(2)) bus64 ();

  imm_gen_pipe #(.XLEN(32), .DEPTH(2)) u_dut32 (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .bus     (bus32)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(2)) u_dut64 (
    .clk     (clk),
    .reset   (reset),
    .flush_i (1'b0),
    .bus     (bus64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] imm, input logic [2:0] fmt,
                       input logic pc, input logic [1:0] cnt);
    chk({tag, ".valid"}, 64'(bus32.out_valid_o), 64'(1));
    chk({tag, ".imm"},   64'(bus32.imm_o),       64'(imm));
    chk({tag, ".fmt"},   64'(bus32.fmt_o),       64'(fmt));
    chk({tag, ".pc_rel"},64'(bus32.pc_rel_o),    64'(pc));
    chk({tag, ".count"}, 64'(bus32.count_o),     64'(cnt));
  endtask

  task automatic chk_empty32(input string tag);
    chk({tag, ".valid"}, 64'(bus32.out_valid_o), 64'(0));
    chk({tag, ".count"}, 64'(bus32.count_o),     64'(0));
  endtask

  // Push one word with out_ready held high; the word shows at the head one cycle later.
  task automatic dec32(input string tag, input logic [31:0] w, input logic [31:0] imm,
                       input logic [2:0] fmt, input logic pc);
    bus32.in_valid_i = 1'b1;
    bus32.instr_i    = w;
    tick();
    bus32.in_valid_i = 1'b0;
    chk32(tag, imm, fmt, pc, 2'd1);
  endtask

  task automatic dec64(input string tag, input logic [31:0] w, input logic [63:0] imm,
                       input logic [2:0] fmt, input logic pc);
    bus64.in_valid_i = 1'b1;
    bus64.instr_i    = w;
    tick();
    bus64.in_valid_i = 1'b0;
    chk({tag, ".valid"}, 64'(bus64.out_valid_o), 64'(1));
    chk({tag, ".imm"},   bus64.imm_o,            imm);
    chk({tag, ".fmt"},   64'(bus64.fmt_o),       64'(fmt));
    chk({tag, ".pc_rel"},64'(bus64.pc_rel_o),    64'(pc));
  endtask

  task automatic push32(input logic [31:0] w);
    bus32.in_valid_i = 1'b1;
    bus32.instr_i    = w;
    tick();
    bus32.in_valid_i = 1'b0;
  endtask

  initial begin
    reset             = 1'b0;
    flush             = 1'b0;
    bus32.in_valid_i  = 1'b0;
    bus32.instr_i     = '0;
    bus32.out_ready_i = 1'b1;
    bus64.in_valid_i  = 1'b0;
    bus64.instr_i     = '0;
    bus64.out_ready_i = 1'b1;

    // Reset state
    #12;
    chk_empty32("rst");
    chk("rst.imm",    64'(bus32.imm_o),    64'(0));
    chk("rst.fmt",    64'(bus32.fmt_o),    64'(0));
    chk("rst.pc_rel", 64'(bus32.pc_rel_o), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("rst.in_ready", 64'(bus32.in_ready_o), 64'(1));

    // Decode table, streamed one word per cycle
    dec32("addi_m1", 32'hFFF0_0093, 32'hFFFF_FFFF, 3'd1, 1'b0);
    dec32("beq_m4",  32'hFE00_0EE3, 32'hFFFF_FFFC, 3'd3, 1'b1);
    dec32("lui",     32'h1234_50B7, 32'h1234_5000, 3'd4, 1'b0);
    dec32("auipc",   32'h0000_1017, 32'h0000_1000, 3'd4, 1'b1);
    dec32("sw_m8",   32'hFE11_2C23, 32'hFFFF_FFF8, 3'd2, 1'b0);
    dec32("jal_800", 32'h0010_00EF, 32'h0000_0800, 3'd5, 1'b1);
    dec32("slli3",   32'h0030_9093, 32'h0000_0003, 3'd6, 1'b0);
    dec32("srai31",  32'h41F0_D093, 32'h0000_001F, 3'd6, 1'b0);
    dec32("unk_op",  32'h0000_000B, 32'h0000_0000, 3'd0, 1'b0);
`ifdef IMM_CSR_ZIMM_EN
    dec32("csrrwi",  32'h340F_D0F3, 32'h0000_001F, 3'd7, 1'b0);
`else
    dec32("csrrwi",  32'h340F_D0F3, 32'h0000_0000, 3'd0, 1'b0);
`endif
    tick();
    chk_empty32("drain0");

    // Backpressure: third word stalls while full, then drains in order
    bus32.out_ready_i = 1'b0;
    bus32.in_valid_i  = 1'b1;
    bus32.instr_i     = 32'h0010_0093;
    tick();
    chk32("bp.a", 32'd1, 3'd1, 1'b0, 2'd1);
    bus32.instr_i = 32'h0020_0093;
    tick();
    chk32("bp.ab", 32'd1, 3'd1, 1'b0, 2'd2);
    bus32.instr_i = 32'h0030_0093;
    #1;
    chk("bp.in_ready_full", 64'(bus32.in_ready_o), 64'(0));
    tick();
    chk32("bp.stall", 32'd1, 3'd1, 1'b0, 2'd2);
    bus32.out_ready_i = 1'b1;
    #1;
    chk("bp.in_ready_pop", 64'(bus32.in_ready_o), 64'(1));
    tick();
    bus32.in_valid_i = 1'b0;
    chk32("bp.b", 32'd2, 3'd1, 1'b0, 2'd2);
    tick();
    chk32("bp.c", 32'd3, 3'd1, 1'b0, 2'd1);
    tick();
    chk_empty32("bp.empty");

    // Full with simultaneous push and pop
    bus32.out_ready_i = 1'b0;
    push32(32'h0010_0093);
    push32(32'h0020_0093);
    chk("sim.full", 64'(bus32.count_o), 64'(2));
    bus32.out_ready_i = 1'b1;
    bus32.in_valid_i  = 1'b1;
    bus32.instr_i     = 32'h0040_0093;
    tick();
    bus32.in_valid_i = 1'b0;
    chk32("sim.b", 32'd2, 3'd1, 1'b0, 2'd2);
    tick();
    chk32("sim.d", 32'd4, 3'd1, 1'b0, 2'd1);
    tick();
    chk_empty32("sim.empty");

    // Flush overrides a same-cycle push
    bus32.out_ready_i = 1'b0;
    push32(32'h0010_0093);
    chk("fl.count1", 64'(bus32.count_o), 64'(1));
    flush            = 1'b1;
    bus32.in_valid_i = 1'b1;
    bus32.instr_i    = 32'h0050_0093;
    #1;
    chk("fl.in_ready", 64'(bus32.in_ready_o), 64'(1));
    tick();
    flush            = 1'b0;
    bus32.in_valid_i = 1'b0;
    chk_empty32("fl.cleared");
    tick();
    chk_empty32("fl.lost");

    // Asynchronous reset mid-traffic with two entries
    push32(32'hFFF0_0093);
    push32(32'h0020_0093);
    chk("ar.full", 64'(bus32.count_o), 64'(2));
    #2;
    reset = 1'b0;
    #1;
    chk_empty32("ar");
    chk("ar.imm",    64'(bus32.imm_o),    64'(0));
    chk("ar.fmt",    64'(bus32.fmt_o),    64'(0));
    chk("ar.pc_rel", 64'(bus32.pc_rel_o), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ar.in_ready", 64'(bus32.in_ready_o), 64'(1));
    chk("ar.count",    64'(bus32.count_o),    64'(0));
    bus32.out_ready_i = 1'b1;

    // XLEN=64 decode
    dec64("x64.slli33", 32'h0210_9093, 64'd33, 3'd6, 1'b0);
    dec64("x64.addi",   32'hFFF0_0093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    dec64("x64.beq",    32'hFE00_0EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b1);
`ifdef IMM_CSR_ZIMM_EN
    dec64("x64.csrrwi", 32'h340F_D0F3, 64'd31, 3'd7, 1'b0);
`else
    dec64("x64.csrrwi", 32'h340F_D0F3, 64'd0, 3'd0, 1'b0);
`endif
    dec64("x64.ecall",  32'h0000_0073, 64'd0, 3'd0, 1'b0);
    tick();
    chk("x64.empty", 64'(bus64.out_valid_o), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
